// File: rtl/pdm_tx.sv
// ---------------------------------------------------------------------------
// pdm_tx -- multi-channel PDM transmitter
//
// Turns one signed PCM sample per channel into one PDM bitstream per channel.
// A single 2nd-order delta-sigma datapath is time-multiplexed across all
// channels: each PDM bit period (one pdm_write_enable strobe) walks through the
// channels, one per clock, and the new bits are then applied to pdm_data all at
// once from a shadow register.
//
// Optional feature (compile-time macro):
//   PDM_TX_DITHER_EN  adds a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed
//                     16'hACE1) whose bit0 is added as +0/+1 LSB to the sample
//                     of the channel being updated. Undefined by default: the
//                     modulator is then fully deterministic.
//
// Parameters:
//   WIDTH      PCM sample width (signed)
//   CHANNELS   number of PDM channels (>= 2)
//   ACC_WIDTH  modulator accumulator width (signed, > WIDTH)
//
// Ports:
//   clk               system clock
//   resetn            asynchronous reset, active low
//   sample_valid      PCM sample write request
//   sample_ready      write accepted when valid & ready (= !busy)
//   sample_channel    target channel; values >= CHANNELS are accepted and dropped
//   sample_data       signed PCM sample
//   pdm_write_enable  one-cycle strobe, one per PDM bit period
//   pdm_data          PDM bitstreams, bit k = channel k
//   busy              modulator update sweep in progress
//   overrun           one-cycle pulse: a strobe arrived while busy and was dropped
// ---------------------------------------------------------------------------
module pdm_tx #(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned CHANNELS  = 8,
    parameter  int unsigned ACC_WIDTH = WIDTH + 4,
    localparam int unsigned CH_W      = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [CH_W-1:0]     sample_channel,
    input  logic [WIDTH-1:0]    sample_data,
    input  logic                pdm_write_enable,
    output logic [CHANNELS-1:0] pdm_data,
    output logic                busy,
    output logic                overrun
);

    // Two guard bits above the accumulator width hold any single-step sum
    // exactly, so saturation can be decided from the extended result.
    localparam int unsigned SW = ACC_WIDTH + 2;

    localparam logic signed [SW-1:0] FS_EXT =
        {{(SW - WIDTH){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    state_t                      state_q;
    logic [CH_W-1:0]             cnt_q;
    logic                        commit_q;
    logic                        overrun_q;
    logic [CHANNELS-1:0]         shadow_q;
    logic [CHANNELS-1:0]         pdm_q;
    logic signed [WIDTH-1:0]     x_q    [CHANNELS];
    logic signed [ACC_WIDTH-1:0] acc1_q [CHANNELS];
    logic signed [ACC_WIDTH-1:0] acc2_q [CHANNELS];
`ifdef PDM_TX_DITHER_EN
    logic [15:0]                 lfsr_q;
    logic [15:0]                 lfsr_d;
`endif

    // Shared modulator datapath for channel cnt_q
    logic signed [SW-1:0]        x_ext;
    logic signed [SW-1:0]        y_ext;
    logic signed [SW-1:0]        a1_ext;
    logic signed [SW-1:0]        a2_ext;
    logic signed [SW-1:0]        sum1;
    logic signed [SW-1:0]        sum2;
    logic signed [ACC_WIDTH-1:0] acc1_d;
    logic signed [ACC_WIDTH-1:0] acc2_d;
    logic                        bit_d;
    logic                        wr_en;

    // Clamp an extended sum into the signed accumulator range.
    function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        logic [SW-ACC_WIDTH:0] top;
        top = v[SW-1:ACC_WIDTH-1];
        if (!v[SW-1] && (top != '0)) begin
            sat = ACC_MAX;
        end else if (v[SW-1] && (top != '1)) begin
            sat = ACC_MIN;
        end else begin
            sat = v[ACC_WIDTH-1:0];
        end
    endfunction

    assign busy         = (state_q == UPDATE);
    assign sample_ready = !busy;
    assign overrun      = overrun_q;
    assign pdm_data     = pdm_q;

    // Out-of-range channels are handshaken but never stored.
    assign wr_en = sample_valid && sample_ready && (32'(sample_channel) < CHANNELS);

`ifdef PDM_TX_DITHER_EN
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`endif

    always_comb begin
        x_ext = {{(SW - WIDTH){x_q[cnt_q][WIDTH-1]}}, x_q[cnt_q]};
`ifdef PDM_TX_DITHER_EN
        x_ext = x_ext + {{(SW - 1){1'b0}}, lfsr_q[0]};
`endif
        a1_ext = {{2{acc1_q[cnt_q][ACC_WIDTH-1]}}, acc1_q[cnt_q]};
        a2_ext = {{2{acc2_q[cnt_q][ACC_WIDTH-1]}}, acc2_q[cnt_q]};
        // Output bit comes from the state before this update.
        bit_d  = !acc2_q[cnt_q][ACC_WIDTH-1];
        y_ext  = bit_d ? FS_EXT : -FS_EXT;
        sum1   = a1_ext + x_ext - y_ext;
        acc1_d = sat(sum1);
        sum2   = a2_ext + {{2{acc1_d[ACC_WIDTH-1]}}, acc1_d} - y_ext;
        acc2_d = sat(sum2);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            commit_q  <= 1'b0;
            overrun_q <= 1'b0;
            shadow_q  <= '0;
            pdm_q     <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                x_q[k]    <= '0;
                acc1_q[k] <= '0;
                acc2_q[k] <= '0;
            end
`ifdef PDM_TX_DITHER_EN
            lfsr_q    <= 16'hACE1;
`endif
        end else begin
            overrun_q <= 1'b0;
            commit_q  <= 1'b0;

            // Apply the completed sweep to all outputs in one edge.
            if (commit_q) begin
                pdm_q <= shadow_q;
            end

            // Only possible in IDLE; a same-edge strobe sweeps with this value.
            if (wr_en) begin
                x_q[sample_channel] <= sample_data;
            end

            case (state_q)
                IDLE: begin
                    if (pdm_write_enable) begin
                        state_q <= UPDATE;
                        cnt_q   <= '0;
                    end
                end
                UPDATE: begin
                    // Any strobe here, including on the final sweep edge, is dropped.
                    overrun_q        <= pdm_write_enable;
                    shadow_q[cnt_q]  <= bit_d;
                    acc1_q[cnt_q]    <= acc1_d;
                    acc2_q[cnt_q]    <= acc2_d;
`ifdef PDM_TX_DITHER_EN
                    lfsr_q           <= lfsr_d;
`endif
                    if (cnt_q == CH_W'(CHANNELS - 1)) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        commit_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_tx.sv
module tb_pdm_tx;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned CHANNELS = 6;
    localparam int unsigned CH_W     = $clog2(CHANNELS);

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                sample_valid = 1'b0;
    logic                sample_ready;
    logic [CH_W-1:0]     sample_channel = '0;
    logic [WIDTH-1:0]    sample_data = '0;
    logic                pdm_write_enable = 1'b0;
    logic [CHANNELS-1:0] pdm_data;
    logic                busy;
    logic                overrun;

    always #5 clk = ~clk;

    pdm_tx #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .ACC_WIDTH (WIDTH + 4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .sample_channel   (sample_channel),
        .sample_data      (sample_data),
        .pdm_write_enable (pdm_write_enable),
        .pdm_data         (pdm_data),
        .busy             (busy),
        .overrun          (overrun)
    );

    typedef struct {
        int unsigned         due;
        logic [CHANNELS-1:0] exp;
        logic [CHANNELS-1:0] mask;
    } exp_t;

    exp_t                sb[$];
    exp_t                cur;
    int unsigned         cyc = 0;
    int unsigned         passed = 0;
    int unsigned         total = 0;
    int unsigned         phase = 0;
    logic [CHANNELS-1:0] dirty = '0;
    logic [CHANNELS-1:0] last_pdm = '0;
    bit                  count_en = 1'b0;
    int unsigned         ones3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: commits are checked at their due cycle, all other cycles must hold.
    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
            last_pdm = '0;
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            cur = sb.pop_front();
            chk("pdm_commit", 64'(pdm_data & cur.mask), 64'(cur.exp & cur.mask));
            if (count_en) ones3 += 32'(pdm_data[3]);
            last_pdm = pdm_data;
        end else begin
            chk("pdm_stable", 64'(pdm_data), 64'(last_pdm));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-input channels from reset emit 1,0,0,1 repeating.
    task automatic push_expect();
        exp_t e;
        e.due  = cyc + CHANNELS + 2;
        e.exp  = ((phase % 4) == 0 || (phase % 4) == 3) ? '1 : '0;
        e.mask = ~dirty;
        sb.push_back(e);
        phase++;
    endtask

    task automatic strobe();
        push_expect();
        pdm_write_enable = 1'b1;
        tick();
        pdm_write_enable = 1'b0;
        repeat (CHANNELS + 1) tick();
    endtask

    task automatic write_sample(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d);
        sample_valid   = 1'b1;
        sample_channel = ch;
        sample_data    = d;
        chk("write_ready", 64'(sample_ready), 64'd1);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pdm"},     64'(pdm_data),     64'd0);
        chk({tag, "_busy"},    64'(busy),         64'd0);
        chk({tag, "_overrun"}, 64'(overrun),      64'd0);
        chk({tag, "_ready"},   64'(sample_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

    initial begin
        // Power-on reset
        repeat (3) tick();
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick();

        // Zero input: 1,0,0,1 on every channel, fixed commit latency
        repeat (64) strobe();

        // ch3 at half scale: density 0.75
        write_sample(3'd3, 16'h4000);
        dirty[3] = 1'b1;
        ones3    = 0;
        count_en = 1'b1;
        repeat (4096) strobe();
        repeat (2) tick();
        count_en = 1'b0;
        total++;
        if (ones3 >= 3032 && ones3 <= 3112) passed++;
        else $display("FAIL ch3_density: actual=%0d required=3072+/-40", ones3);

        // Reset in the middle of a sweep
        pdm_write_enable = 1'b1;
        tick();
        pdm_write_enable = 1'b0;
        repeat (2) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        chk("pre_reset_pdm_set", 64'(pdm_data != '0), 64'd1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        phase = 0;
        dirty = '0;
        tick();
        resetn = 1'b1;
        tick();

        // Write held during a sweep: stalled until IDLE, affects only the next sweep
        push_expect();
        pdm_write_enable = 1'b1;
        tick();
        pdm_write_enable = 1'b0;
        sample_valid     = 1'b1;
        sample_channel   = 3'd5;
        sample_data      = 16'h7FFF;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            chk("ready_low_busy", 64'(sample_ready), 64'd0);
            tick();
        end
        chk("ready_back_idle", 64'(sample_ready), 64'd1);
        tick();
        sample_valid = 1'b0;
        // With a leak into the running sweep, ch5's third bit would be 1.
        strobe();
        strobe();
        dirty[5] = 1'b1;

        // Overrun: strobe at T+2 and on the final sweep edge
        push_expect();
        pdm_write_enable = 1'b1;
        tick();
        pdm_write_enable = 1'b0;
        chk("ovr_first", 64'(overrun), 64'd0);
        tick();
        pdm_write_enable = 1'b1;
        tick();
        pdm_write_enable = 1'b0;
        chk("ovr_t2", 64'(overrun), 64'd1);
        for (int i = 3; i < int'(CHANNELS); i++) begin
            tick();
            chk("ovr_quiet", 64'(overrun), 64'd0);
            chk("ovr_busy", 64'(busy), 64'd1);
        end
        pdm_write_enable = 1'b1;
        tick();
        pdm_write_enable = 1'b0;
        chk("ovr_last_edge", 64'(overrun), 64'd1);
        chk("ovr_last_idle", 64'(busy), 64'd0);
        tick();
        chk("ovr_clear", 64'(overrun), 64'd0);
        chk("ovr_no_restart", 64'(busy), 64'd0);
        repeat (3) tick();

        // Out-of-range channels are dropped
        write_sample(3'd6, 16'h7FFF);
        write_sample(3'd7, 16'h8000);
        repeat (8) strobe();

        repeat (4) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
